// File: rtl/stream_width_cast.sv
// Resizes each stream beat from IN_W to OUT_W bits (sign/zero extend, truncate or clamp) behind a 2-entry skid buffer.
// Latency: one cycle from acceptance into an empty buffer to out_valid.
// Backpressure: in_ready drops only when both entries are full and is a function of buffer state alone.
module stream_width_cast #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 3,
    parameter int SAT   = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_clamped,
    output logic [CNT_W-1:0] sat_cnt
);

    // Cast result for the beat currently on the input, stored at push time.
    logic [OUT_W-1:0] cast_data;
    logic             cast_clamped;

    generate
        if (OUT_W >= IN_W) begin : g_widen
            if (OUT_W == IN_W) begin : g_same
                wire unused_sign = in_signed;
                assign cast_data = in_data;
            end else begin : g_ext
                logic ext_bit;
                assign ext_bit   = in_signed & in_data[IN_W-1];
                assign cast_data = {{(OUT_W-IN_W){ext_bit}}, in_data};
            end
            assign cast_clamped = 1'b0;
        end else if (SAT == 0) begin : g_trunc
            // Truncation ignores signedness and the dropped high bits entirely.
            wire unused_hi = ^{in_signed, in_data[IN_W-1:OUT_W]};
            assign cast_data    = in_data[OUT_W-1:0];
            assign cast_clamped = 1'b0;
        end else begin : g_clamp
            localparam logic [OUT_W-1:0] SMIN = OUT_W'(1) << (OUT_W-1);
            localparam logic [OUT_W-1:0] SMAX = ~SMIN;
            localparam logic [OUT_W-1:0] UMAX = '1;

            logic [IN_W-OUT_W:0] s_top;   // bits that must all match the result sign
            logic                s_fit;
            logic                u_fit;

            assign s_top = in_data[IN_W-1:OUT_W-1];
            assign s_fit = (s_top == '0) || (s_top == '1);
            assign u_fit = (in_data[IN_W-1:OUT_W] == '0);

            // Out-of-range values go to the nearest bound; the input MSB tells which side for signed beats.
            always_comb begin
                cast_data    = in_data[OUT_W-1:0];
                cast_clamped = 1'b0;
                if (in_signed) begin
                    if (!s_fit) begin
                        cast_data    = in_data[IN_W-1] ? SMIN : SMAX;
                        cast_clamped = 1'b1;
                    end
                end else begin
                    if (!u_fit) begin
                        cast_data    = UMAX;
                        cast_clamped = 1'b1;
                    end
                end
            end
        end
    endgenerate

    logic [OUT_W-1:0] mem_data  [2];
    logic             mem_clamp [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign in_ready    = !rst && (count != 2'd2);
    assign out_valid   = (count != 2'd0);
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign out_data    = mem_data[rd_ptr];
    assign out_clamped = mem_clamp[rd_ptr];

    // Two-entry ring: write at wr_ptr, head at rd_ptr; reset discards any buffered beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_data[0]  <= '0;
            mem_data[1]  <= '0;
            mem_clamp[0] <= 1'b0;
            mem_clamp[1] <= 1'b0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
        end else begin
            if (push) begin
                mem_data[wr_ptr]  <= cast_data;
                mem_clamp[wr_ptr] <= cast_clamped;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Count clamped beats at acceptance, sticking at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (push && cast_clamped && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + CNT_W'(1);
        end
    end

endmodule
